// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and receiver state encoding for the PS/2 key capture block
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - ps2_clk/ps2_data synchroniser with falling-edge strobe
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Both lines take the same path so data_s is aligned with the fall strobe; idle lines are high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_capture.sv
// rtl/ps2_key_capture.sv - PS/2 frame receiver with make/break decode and press counter
module ps2_key_capture
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_en,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] press_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic data_s;
  logic fall;

  ps2_state_e state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          break_pend_q, break_pend_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_en_q, key_en_d;
  logic [7:0]    press_cnt_q, press_cnt_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .fall    (fall)
  );

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tcnt_q       <= '0;
      break_pend_q <= 1'b0;
      key_code_q   <= '0;
      key_en_q     <= 1'b0;
      press_cnt_q  <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tcnt_q       <= tcnt_d;
      break_pend_q <= break_pend_d;
      key_code_q   <= key_code_d;
      key_en_q     <= key_en_d;
      press_cnt_q  <= press_cnt_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame FSM, stall timeout and make/break decode; a fall strobe overrides a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tcnt_d       = tcnt_q;
    break_pend_d = break_pend_q;
    key_code_d   = key_code_q;
    key_en_d     = key_en_q;
    press_cnt_d  = press_cnt_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_d  = '0;
      state_d = ST_IDLE;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            code_valid_d = 1'b1;
            if (shift_q == PS2_BREAK) begin
              break_pend_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              break_pend_d = break_pend_q;
            end else if (break_pend_q) begin
              break_pend_d = 1'b0;
              if (shift_q == key_code_q) key_en_d = 1'b0;
            end else begin
              if (!key_en_q || shift_q != key_code_q) press_cnt_d = press_cnt_q + 8'd1;
              key_code_d = shift_q;
              key_en_d   = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_code   = key_code_q;
  assign key_en     = key_en_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign press_cnt  = press_cnt_q;

endmodule
